vector_logic_decoder: RTL and testbench

VECTOR_LOGIC_DECODER -- requirements
Module: vector_logic_decoder

---
 rtl/vector_logic_decoder.sv | 147 ++++++++++++++
 tb/tb_vector_logic_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_logic_decoder.sv
// Decoder for RVV vand/vor/vxor with a two-entry output skid buffer.
// Illegal instructions decode to a disabled record and bump a saturating counter.
package vector_logic_pkg;
   typedef enum logic [1:0] {
      DISABLED_LOGIC_MODE = 2'd0,
      ENABLED_AND_MODE    = 2'd1,
      ENABLED_OR_MODE     = 2'd2,
      ENABLED_XOR_MODE    = 2'd3
   } logic_mode_t;

   typedef struct packed {
      logic        logic_enable;
      logic_mode_t logic_mode;
   } execution_vector_t;
endpackage

module vector_logic_decoder
   import vector_logic_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   instruction_valid,
   input  logic [31:0]            instruction,
   output logic                   instruction_ready,
   output logic                   decode_valid,
   input  logic                   decode_ready,
   output execution_vector_t      execution_vector,
   output logic [4:0]             vs2_index,
   output logic [4:0]             vs1_index,
   output logic [4:0]             vd_index,
   output logic [1:0]             operand_source,
   output logic                   vm,
   output logic                   illegal,
   output logic [COUNT_WIDTH-1:0] illegal_count
);

   typedef struct packed {
      execution_vector_t ev;
      logic [4:0]        vs2;
      logic [4:0]        vs1;
      logic [4:0]        vd;
      logic [1:0]        src;
      logic              vm;
      logic              illegal;
   } record_t;

   localparam record_t IDLE_REC = '{
      ev:      '{logic_enable: 1'b0, logic_mode: DISABLED_LOGIC_MODE},
      vs2:     5'd0,
      vs1:     5'd0,
      vd:      5'd0,
      src:     2'b11,
      vm:      1'b0,
      illegal: 1'b0
   };

   record_t     dec_rec;
   record_t     out_rec;
   record_t     skid_rec;
   logic        out_valid;
   logic        skid_valid;
   logic        ready_q;
   logic        accept;
   logic        take;
   logic        legal;
   logic_mode_t mode;
   logic [1:0]  src;

   always_comb begin
      mode = DISABLED_LOGIC_MODE;
      src  = 2'b11;
      unique case (instruction[31:26])
         6'b001001: mode = ENABLED_AND_MODE;
         6'b001010: mode = ENABLED_OR_MODE;
         6'b001011: mode = ENABLED_XOR_MODE;
         default:   mode = DISABLED_LOGIC_MODE;
      endcase
      unique case (instruction[14:12])
         3'b000:  src = 2'b00;
         3'b100:  src = 2'b01;
         3'b011:  src = 2'b10;
         default: src = 2'b11;
      endcase
      legal = (instruction[6:0] == 7'b1010111)
            && (mode != DISABLED_LOGIC_MODE)
            && (src != 2'b11);
      dec_rec.vs2     = instruction[24:20];
      dec_rec.vs1     = instruction[19:15];
      dec_rec.vd      = instruction[11:7];
      dec_rec.vm      = instruction[25];
      dec_rec.illegal = !legal;
      dec_rec.src     = legal ? src : 2'b11;
      dec_rec.ev.logic_enable = legal;
      dec_rec.ev.logic_mode   = legal ? mode : DISABLED_LOGIC_MODE;
   end

   assign accept = instruction_valid && ready_q;
   assign take   = out_valid && decode_ready;

   // ready_q mirrors "skid empty" as a flop, so decode_ready never reaches it combinationally
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid     <= 1'b0;
         skid_valid    <= 1'b0;
         ready_q       <= 1'b1;
         out_rec       <= IDLE_REC;
         skid_rec      <= IDLE_REC;
         illegal_count <= '0;
      end else begin
         if (take) begin
            if (skid_valid) begin
               out_rec    <= skid_rec;
               skid_valid <= 1'b0;
               ready_q    <= 1'b1;
            end else if (accept) begin
               out_rec <= dec_rec;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            if (out_valid) begin
               skid_rec   <= dec_rec;
               skid_valid <= 1'b1;
               ready_q    <= 1'b0;
            end else begin
               out_rec   <= dec_rec;
               out_valid <= 1'b1;
            end
         end
         if (accept && dec_rec.illegal && (illegal_count != '1))
            illegal_count <= illegal_count + COUNT_WIDTH'(1);
      end
   end

   assign instruction_ready = ready_q;
   assign decode_valid      = out_valid;
   assign execution_vector  = out_rec.ev;
   assign vs2_index         = out_rec.vs2;
   assign vs1_index         = out_rec.vs1;
   assign vd_index          = out_rec.vd;
   assign operand_source    = out_rec.src;
   assign vm                = out_rec.vm;
   assign illegal           = out_rec.illegal;

endmodule

// File: tb/tb_vector_logic_decoder.sv
// Scoreboard bench for vector_logic_decoder (COUNT_WIDTH=2).
// Driver queues expected records on acceptance; a negedge monitor checks them.
module tb_vector_logic_decoder;
   import vector_logic_pkg::*;

   typedef struct {
      logic_mode_t mode;
      logic [1:0]  src;
      logic [4:0]  vs2;
      logic [4:0]  vs1;
      logic [4:0]  vd;
      logic        vm;
      logic        ill;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              instruction_valid = 1'b0;
   logic [31:0]       instruction = '0;
   logic              instruction_ready;
   logic              decode_valid;
   logic              decode_ready = 1'b1;
   execution_vector_t execution_vector;
   logic [4:0]        vs2_index;
   logic [4:0]        vs1_index;
   logic [4:0]        vd_index;
   logic [1:0]        operand_source;
   logic              vm;
   logic              illegal;
   logic [1:0]        illegal_count;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_pop = 0;
   int   prev_pop = 0;
   int   model_cnt = 0;
   exp_t drv_exp;
   exp_t q[$];

   vector_logic_decoder #(.COUNT_WIDTH(2)) dut (
      .clock(clock),
      .reset(reset),
      .instruction_valid(instruction_valid),
      .instruction(instruction),
      .instruction_ready(instruction_ready),
      .decode_valid(decode_valid),
      .decode_ready(decode_ready),
      .execution_vector(execution_vector),
      .vs2_index(vs2_index),
      .vs1_index(vs1_index),
      .vd_index(vd_index),
      .operand_source(operand_source),
      .vm(vm),
      .illegal(illegal),
      .illegal_count(illegal_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] enc(input logic [5:0] f6, input logic m,
      input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3,
      input logic [4:0] d);
      return {f6, m, s2, s1, f3, d, 7'b1010111};
   endfunction

   function automatic exp_t mk(input logic_mode_t md, input logic [1:0] s,
      input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d,
      input logic m, input logic il);
      exp_t e;
      e.mode = md; e.src = s; e.vs2 = s2; e.vs1 = s1;
      e.vd = d; e.vm = m; e.ill = il;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_rec(input string name, input exp_t e);
      checks++;
      if (execution_vector.logic_mode !== e.mode
          || execution_vector.logic_enable !== !e.ill
          || operand_source !== e.src || vs2_index !== e.vs2
          || vs1_index !== e.vs1 || vd_index !== e.vd
          || vm !== e.vm || illegal !== e.ill) begin
         failures++;
         $display("FAIL %s: got mode=%0d en=%0b src=%0d vs2=%0d vs1=%0d vd=%0d vm=%0b ill=%0b expected mode=%0d en=%0b src=%0d vs2=%0d vs1=%0d vd=%0d vm=%0b ill=%0b",
            name, execution_vector.logic_mode, execution_vector.logic_enable,
            operand_source, vs2_index, vs1_index, vd_index, vm, illegal,
            e.mode, !e.ill, e.src, e.vs2, e.vs1, e.vd, e.vm, e.ill);
      end
   endtask

   // Monitor: check front record each valid cycle; pop on handshake
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         q.delete();
         model_cnt = 0;
      end else begin
         if (decode_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_record: got decode_valid=1 expected 0");
            end else begin
               cmp_rec(decode_ready ? "record" : "held_record", q[0]);
               if (decode_ready) begin
                  void'(q.pop_front());
                  chk("illegal_count", int'(illegal_count), model_cnt);
                  prev_pop = last_pop;
                  last_pop = cyc;
               end
            end
         end
         if (instruction_valid && instruction_ready === 1'b1) begin
            q.push_back(drv_exp);
            if (drv_exp.ill && model_cnt != 3) model_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] ins, input exp_t e);
      instruction_valid = 1'b1;
      instruction = ins;
      drv_exp = e;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (instruction_ready === 1'b1) begin
            @(posedge clock);
            #1;
            instruction_valid = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected 1");
      instruction_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50; i++) begin
         @(posedge clock);
         #2;
         if (q.size() == 0) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, q.size());
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_decode_valid", int'(decode_valid), 0);
      chk("rst_instruction_ready", int'(instruction_ready), 1);
      chk("rst_illegal_count", int'(illegal_count), 0);
      chk("rst_operand_source", int'(operand_source), 3);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_logic_mode", int'(execution_vector.logic_mode), 0);
      chk("rst_indices", int'({vs2_index, vs1_index, vd_index, vm}), 0);
      @(posedge clock);
      #1;

      send(32'h26208057, mk(ENABLED_AND_MODE, 2'b00, 5'd2, 5'd1, 5'd0, 1'b1, 1'b0));
      drain("vand");

      send(enc(6'b001010, 1'b1, 5'd3, 5'd5, 3'b011, 5'd4),
           mk(ENABLED_OR_MODE, 2'b10, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0));
      send(enc(6'b001011, 1'b0, 5'd7, 5'd9, 3'b100, 5'd31),
           mk(ENABLED_XOR_MODE, 2'b01, 5'd7, 5'd9, 5'd31, 1'b0, 1'b0));
      drain("or_xor");
      chk("no_bubble", last_pop - prev_pop, 1);

      decode_ready = 1'b0;
      send(enc(6'b001001, 1'b0, 5'd10, 5'd11, 3'b000, 5'd12),
           mk(ENABLED_AND_MODE, 2'b00, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0));
      send(enc(6'b001010, 1'b1, 5'd13, 5'd14, 3'b100, 5'd15),
           mk(ENABLED_OR_MODE, 2'b01, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0));
      @(negedge clock);
      chk("stall_ready", int'(instruction_ready), 0);
      chk("stall_valid", int'(decode_valid), 1);
      repeat (3) @(posedge clock);
      #1 decode_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("unstall_ready", int'(instruction_ready), 1);
      chk("unstall_empty", int'(decode_valid), 0);
      chk("unstall_pending", q.size(), 0);
      @(posedge clock);
      #1;

      send(32'h00000013, mk(DISABLED_LOGIC_MODE, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1));
      drain("addi");
      @(negedge clock);
      chk("addi_count", int'(illegal_count), 1);
      @(posedge clock);
      #1;

      send(enc(6'b001001, 1'b1, 5'd1, 5'd2, 3'b001, 5'd3),
           mk(DISABLED_LOGIC_MODE, 2'b11, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1));
      send(enc(6'b000000, 1'b0, 5'd4, 5'd5, 3'b000, 5'd6),
           mk(DISABLED_LOGIC_MODE, 2'b11, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1));
      send(32'h26208077, mk(DISABLED_LOGIC_MODE, 2'b11, 5'd2, 5'd1, 5'd0, 1'b1, 1'b1));
      send(32'hFFFFFFFF, mk(DISABLED_LOGIC_MODE, 2'b11, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1));
      send(enc(6'b001011, 1'b0, 5'd8, 5'd9, 3'b111, 5'd10),
           mk(DISABLED_LOGIC_MODE, 2'b11, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1));
      drain("illegal_burst");
      repeat (2) @(negedge clock);
      chk("sat_count", int'(illegal_count), 3);
      @(posedge clock);
      #1;

      decode_ready = 1'b0;
      send(enc(6'b001001, 1'b1, 5'd1, 5'd1, 3'b000, 5'd1),
           mk(ENABLED_AND_MODE, 2'b00, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0));
      send(enc(6'b001011, 1'b1, 5'd2, 5'd2, 3'b011, 5'd2),
           mk(ENABLED_XOR_MODE, 2'b10, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0));
      reset = 1'b1;
      instruction_valid = 1'b1;
      instruction = enc(6'b001010, 1'b1, 5'd3, 5'd3, 3'b000, 5'd3);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      instruction_valid = 1'b0;
      decode_ready = 1'b1;
      @(negedge clock);
      chk("mid_rst_valid", int'(decode_valid), 0);
      chk("mid_rst_ready", int'(instruction_ready), 1);
      chk("mid_rst_count", int'(illegal_count), 0);
      @(posedge clock);
      #1;

      send(enc(6'b001010, 1'b0, 5'd20, 5'd21, 3'b000, 5'd22),
           mk(ENABLED_OR_MODE, 2'b00, 5'd20, 5'd21, 5'd22, 1'b0, 1'b0));
      drain("post_reset");
      repeat (2) @(posedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
